apb_master_xbar: RTL and testbench

Parametrised APB requester with integrated N-way slave decode, replacing the fixed two-slave, PADDR[8]-steered arrangement in the current top. It accepts single read/write commands on a valid/ready interface and runs a full SETUP/ACCESS APB transfer to the decoded slave. It muxes PREADY/PRDATA/PSLVERR back from that slave and returns one response per command. It sits between the command source (test top / CPU stub) and the APB slaves.

---
 rtl/apb_master_xbar.sv | 208 ++++++++++++++++++++
 tb/tb_apb_master_xbar.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_xbar.sv
// apb_master_xbar: single-command APB requester with an integrated N-way slave
// decode. Commands arrive on a valid/ready port, run one SETUP/ACCESS transfer
// to the slave picked by the top address bits, and return one response strobe.
// Optional ACCESS-phase timeout: define APB_TIMEOUT_EN.
//
// Handshake: a command transfers on a rising PCLK edge where cmd_valid_i and
// cmd_ready_o are both high; cmd_ready_o is high only in IDLE and cmd_valid_i is
// ignored elsewhere. rsp_valid_o is a one-cycle strobe with no backpressure.
module apb_master_xbar #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 9,
    parameter int NUM_SLAVES  = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic                         cmd_write_i,
    input  logic [ADDR_W-1:0]            cmd_addr_i,
    input  logic [DATA_W-1:0]            cmd_wdata_i,
    output logic                         rsp_valid_o,
    output logic [DATA_W-1:0]            rsp_rdata_o,
    output logic                         rsp_err_o,
    output logic [NUM_SLAVES-1:0]        PSEL_o,
    output logic                         PENABLE_o,
    output logic                         PWRITE_o,
    output logic [ADDR_W-1:0]            PADDR_o,
    output logic [DATA_W-1:0]            PWDATA_o,
    input  logic [NUM_SLAVES-1:0]        PREADY_i,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA_i,
    input  logic [NUM_SLAVES-1:0]        PSLVERR_i
);

    localparam int SEL_BITS = $clog2(NUM_SLAVES);
    // A single slave needs no select bits; keep a 1-bit index so vectors stay legal.
    localparam int SEL_W = (SEL_BITS > 0) ? SEL_BITS : 1;
    localparam logic [SEL_W:0] NUM_SLAVES_W = (SEL_W+1)'(NUM_SLAVES);

    // Parameter range check at elaboration.
    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("apb_master_xbar: NUM_SLAVES must be 1..16 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [SEL_W-1:0]   cmd_idx;
    logic               cmd_mapped;
    logic               sel_ready;
    logic               sel_err;
    logic [DATA_W-1:0]  sel_rdata;

    // Slave index comes from the top address bits; one slave takes everything.
    if (SEL_BITS == 0) begin : g_single
        assign cmd_idx = '0;
    end else begin : g_multi
        assign cmd_idx = cmd_addr_i[ADDR_W-1 -: SEL_BITS];
    end

    assign cmd_mapped = ({1'b0, cmd_idx} < NUM_SLAVES_W);

    // Return-path mux: only the latched slave's PREADY/PSLVERR/PRDATA matter.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == SEL_W'(k)) begin
                sel_ready = PREADY_i[k];
                sel_err   = PSLVERR_i[k];
                sel_rdata = PRDATA_i[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_hit;

    // Count ACCESS cycles without PREADY; restart while in SETUP.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = '0;
        end else if (state_q == ACCESS && !sel_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit = (cnt_d == CNT_W'(TIMEOUT_CYC));

    // Timeout counter register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // State and transfer registers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            idx_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            idx_q    <= idx_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Next state, command latch and response capture.
    always_comb begin
        state_d  = state_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        idx_d    = idx_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    pwrite_d = cmd_write_i;
                    paddr_d  = cmd_addr_i;
                    pwdata_d = cmd_wdata_i;
                    idx_d    = cmd_idx;
                    if (cmd_mapped) begin
                        state_d = SETUP;
                    end else begin
                        // Unmapped: answer immediately, the bus is never touched.
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    rdata_d = pwrite_q ? '0 : sel_rdata;
                    err_d   = sel_err;
                    state_d = RESP;
                end
`ifdef APB_TIMEOUT_EN
                else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus and handshake outputs decoded from state so reset drops them at once.
    always_comb begin
        cmd_ready_o = (state_q == IDLE);
        rsp_valid_o = (state_q == RESP);
        PENABLE_o   = (state_q == ACCESS);
        PSEL_o      = '0;
        if (state_q == SETUP || state_q == ACCESS) begin
            for (int k = 0; k < NUM_SLAVES; k++) begin
                PSEL_o[k] = (idx_q == SEL_W'(k));
            end
        end
    end

    assign PWRITE_o    = pwrite_q;
    assign PADDR_o     = paddr_q;
    assign PWDATA_o    = pwdata_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_apb_master_xbar.sv
// Bench for apb_master_xbar: a two-slave instance driven from a vector table,
// plus a three-slave instance for the unmapped-address path.
module tb_apb_master_xbar;
  localparam int DW = 8;
  localparam int AW = 9;
  localparam int NS = 2;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  // two-slave instance
  logic           cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0]  cmd_addr = '0;
  logic [DW-1:0]  cmd_wdata = '0;
  logic           cmd_ready, rsp_valid, rsp_err, penable, pwrite;
  logic [DW-1:0]  rsp_rdata, pwdata;
  logic [AW-1:0]  paddr;
  logic [NS-1:0]  psel;
  logic [NS-1:0]  pready = '0, pslverr = '0;
  logic [NS*DW-1:0] prdata = '0;

  apb_master_xbar #(.DATA_W(DW), .ADDR_W(AW), .NUM_SLAVES(NS), .TIMEOUT_CYC(TO)) u_dut (
    .PCLK(clk), .PRESET(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .PSEL_o(psel), .PENABLE_o(penable), .PWRITE_o(pwrite), .PADDR_o(paddr),
    .PWDATA_o(pwdata), .PREADY_i(pready), .PRDATA_i(prdata), .PSLVERR_i(pslverr)
  );

  // three-slave instance (slaves always ready, fixed read data)
  logic           c3_valid = 1'b0;
  logic [AW-1:0]  c3_addr = '0;
  logic           c3_ready, r3_valid, r3_err, pen3, pwr3;
  logic [DW-1:0]  r3_rdata, pwd3;
  logic [AW-1:0]  pad3;
  logic [2:0]     psel3;
  logic [2:0]     pready3 = 3'b111;
  logic [2:0]     pslverr3 = 3'b000;
  logic [3*DW-1:0] prdata3 = {8'hA2, 8'hA1, 8'hA0};

  apb_master_xbar #(.DATA_W(DW), .ADDR_W(AW), .NUM_SLAVES(3), .TIMEOUT_CYC(TO)) u_dut3 (
    .PCLK(clk), .PRESET(rst),
    .cmd_valid_i(c3_valid), .cmd_ready_o(c3_ready), .cmd_write_i(1'b0),
    .cmd_addr_i(c3_addr), .cmd_wdata_i(8'h00),
    .rsp_valid_o(r3_valid), .rsp_rdata_o(r3_rdata), .rsp_err_o(r3_err),
    .PSEL_o(psel3), .PENABLE_o(pen3), .PWRITE_o(pwr3), .PADDR_o(pad3),
    .PWDATA_o(pwd3), .PREADY_i(pready3), .PRDATA_i(prdata3), .PSLVERR_i(pslverr3)
  );

  int checks = 0;
  int failures = 0;
  logic [DW:0] exp_q[$];  // {err, rdata} expected per response

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;      // ACCESS cycles with PREADY low
    logic [DW-1:0] prd;        // selected slave PRDATA
    logic          slverr;     // selected slave PSLVERR
    logic [NS-1:0] exp_sel;
    int            exp_lat;    // cycles from accept edge to rsp_valid
    int            exp_psel;   // cycles with PSEL asserted
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: one command on the two-slave instance, acting as the slave too
  task automatic run_txn(input vec_t v, input int n);
    int sel, acc, psel_cyc, lat;
    bit got;
    logic [DW:0] e;
    sel = int'(v.addr[AW-1]);
    @(negedge clk);
    check($sformatf("v%0d cmd_ready", n), cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    // non-selected slave is ready/erroring with other data: must be ignored
    prdata = {NS{~v.prd}};
    prdata[sel*DW +: DW] = v.prd;
    pready = '1;  pready[sel] = 1'b0;
    pslverr = '1; pslverr[sel] = v.slverr;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    acc = 0; psel_cyc = 0; lat = 0; got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (c == 1) begin
        check($sformatf("v%0d setup_psel", n), psel, v.exp_sel);
        check($sformatf("v%0d setup_penable", n), penable, 0);
      end
      if (rsp_valid) begin
        lat = c; got = 1'b1;
        e = exp_q.pop_front();
        check($sformatf("v%0d rsp_rdata", n), rsp_rdata, e[DW-1:0]);
        check($sformatf("v%0d rsp_err", n), rsp_err, e[DW]);
        check($sformatf("v%0d resp_psel", n), psel, 0);
      end else begin
        if (psel != '0) begin
          psel_cyc++;
          check($sformatf("v%0d psel", n), psel, v.exp_sel);
          check($sformatf("v%0d paddr", n), paddr, v.addr);
          check($sformatf("v%0d pwrite", n), pwrite, v.wr);
          if (v.wr) check($sformatf("v%0d pwdata", n), pwdata, v.wdata);
        end
        if (penable) begin
          acc++;
          pready[sel] = (acc > v.waits);
        end else begin
          pready[sel] = 1'b0;
        end
      end
    end
    if (!got) void'(exp_q.pop_front());
    check($sformatf("v%0d latency", n), lat, v.exp_lat);
    check($sformatf("v%0d psel_cycles", n), psel_cyc, v.exp_psel);
    @(negedge clk);
    check($sformatf("v%0d rsp_one_cycle", n), rsp_valid, 0);
    check($sformatf("v%0d ready_after", n), cmd_ready, 1);
    check($sformatf("v%0d rdata_hold", n), rsp_rdata, v.exp_rdata);
    pready = '0; pslverr = '0;
  endtask

  // driver: one read on the three-slave instance
  task automatic u3_txn(input string name, input logic [AW-1:0] addr, input logic [2:0] exp_sel,
                        input int exp_lat, input int exp_psel, input logic [DW-1:0] exp_rdata,
                        input logic exp_err);
    int lat, psel_cyc;
    bit got;
    @(negedge clk);
    check({name, " ready"}, c3_ready, 1);
    c3_valid = 1'b1; c3_addr = addr;
    lat = 0; psel_cyc = 0; got = 1'b0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      c3_valid = 1'b0;
      if (psel3 != '0) begin
        psel_cyc++;
        check({name, " psel"}, psel3, exp_sel);
      end
      if (r3_valid) begin
        lat = c; got = 1'b1;
        check({name, " rdata"}, r3_rdata, exp_rdata);
        check({name, " err"}, r3_err, exp_err);
      end
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " psel_cycles"}, psel_cyc, exp_psel);
  endtask

  // reset with no clock edge in between and check every output clears
  task automatic reset_and_check(input string name);
    #2 rst = 1'b1;
    #1;
    check({name, " psel"}, psel, 0);
    check({name, " penable"}, penable, 0);
    check({name, " cmd_ready"}, cmd_ready, 1);
    check({name, " rsp_valid"}, rsp_valid, 0);
    check({name, " rsp_rdata"}, rsp_rdata, 0);
    check({name, " rsp_err"}, rsp_err, 0);
    check({name, " pwrite"}, pwrite, 0);
    check({name, " paddr"}, paddr, 0);
    check({name, " pwdata"}, pwdata, 0);
    check({name, " u3_psel"}, psel3, 0);
    @(negedge clk);
    check({name, " rsp_in_reset"}, rsp_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    check({name, " rsp_after_release"}, rsp_valid, 0);
    check({name, " ready_after_release"}, cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    bit got;

    //            wr    addr     wdata  wt prd    slv   sel    lat psel rdata  err
    vecs[0] = '{1'b1, 9'h010, 8'h5A, 0, 8'hEE, 1'b0, 2'b01, 3, 2, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 9'h1F0, 8'h00, 3, 8'hC3, 1'b0, 2'b10, 6, 5, 8'hC3, 1'b0};
    vecs[2] = '{1'b0, 9'h020, 8'h00, 1, 8'h77, 1'b1, 2'b01, 4, 3, 8'h77, 1'b1};
    vecs[3] = '{1'b0, 9'h030, 8'h00, 0, 8'h3C, 1'b0, 2'b01, 3, 2, 8'h3C, 1'b0};
    vecs[4] = '{1'b1, 9'h1AB, 8'h81, 2, 8'h99, 1'b1, 2'b10, 5, 4, 8'h00, 1'b1};
    vecs[5] = '{1'b0, 9'h100, 8'h00, 0, 8'hFF, 1'b0, 2'b10, 3, 2, 8'hFF, 1'b0};

    #1 rst = 1'b1;
    #2;
    check("reset cmd_ready", cmd_ready, 1);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_rdata", rsp_rdata, 0);
    check("reset rsp_err", rsp_err, 0);
    check("reset psel", psel, 0);
    check("reset penable", penable, 0);
    check("reset pwrite", pwrite, 0);
    check("reset paddr", paddr, 0);
    check("reset pwdata", pwdata, 0);
    check("reset u3_ready", c3_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

    // PREADY stuck low on slave 0
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h010;
    pready = '0; pslverr = '0; prdata = 16'h5555;
    lat = 0; got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (rsp_valid) begin
        lat = c; got = 1'b1;
        check("stuck rsp_err", rsp_err, 1);
        check("stuck rsp_rdata", rsp_rdata, 0);
      end
    end
`ifdef APB_TIMEOUT_EN
    check("stuck timeout_latency", lat, 6);
    @(negedge clk);
`else
    check("stuck no_response", got, 0);
    check("stuck still_psel", psel, 2'b01);
    check("stuck still_penable", penable, 1);
    reset_and_check("stuck_recover");
`endif

    // reset in the middle of ACCESS
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h1F0; pready = '0;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    check("mid precondition penable", penable, 1);
    check("mid precondition psel", psel, 2'b10);
    reset_and_check("mid_reset");
    run_txn(vecs[0], 6);

    // three-slave decode
    u3_txn("u3 slave2", 9'h100, 3'b100, 3, 2, 8'hA2, 1'b0);
    u3_txn("u3 slave1", 9'h080, 3'b010, 3, 2, 8'hA1, 1'b0);
    u3_txn("u3 unmapped", 9'h1C0, 3'b000, 1, 0, 8'h00, 1'b1);
    @(negedge clk);
    check("u3 rsp_one_cycle", r3_valid, 0);
    check("u3 err_hold", r3_err, 1);

    check("scoreboard empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
